// File: rtl/aptpu_pkg.sv
// Shared constants and the split-result record for the sign/magnitude front end.
package aptpu_pkg;

  localparam int BW_DEF    = 8;
  localparam int CNT_W_DEF = 16;
  // Widest operand the shared record can carry; narrower builds zero-extend.
  localparam int MAG_W_MAX = 32;

  typedef struct packed {
    logic                 a_sign;
    logic                 b_sign;
    logic                 prod_sign;
    logic                 zero_op;
    logic [MAG_W_MAX-1:0] a_mag;
    logic [MAG_W_MAX-1:0] b_mag;
  } split_t;

  // Product sign for the re-signing stage; a zero product is always positive
  // when zero detection is active.
  function automatic logic prod_sign_of(input logic sa, input logic sb,
                                        input logic zero);
    return zero ? 1'b0 : (sa ^ sb);
  endfunction

endpackage

// File: rtl/abs_val.sv
// Two's-complement to sign/magnitude for one operand. The magnitude of the
// most-negative value wraps to 2^(BW-1), which is exact as an unsigned value.
module abs_val #(
  parameter int BW = 8
) (
  input  logic [BW-1:0] x,
  output logic          sign,
  output logic [BW-1:0] mag
);

  assign sign = x[BW-1];
  assign mag  = sign ? (~x + BW'(1)) : x;

endmodule

// File: rtl/sign_mag_split.sv
// Splits a pair of signed operands into signs and unsigned magnitudes for an
// unsigned multiplier, behind a two-entry (main + skid) ready/valid buffer.
// Optional build macro: SIGN_MAG_ZERO_SKIP_EN enables zero-operand detection.
module sign_mag_split
  import aptpu_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    a,
  input  logic [BW-1:0]    b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_sign,
  output logic             b_sign,
  output logic [BW-1:0]    a_mag,
  output logic [BW-1:0]    b_mag,
  output logic             prod_sign,
  output logic             zero_op,
  output logic [CNT_W-1:0] op_count
);

  logic [1:0][BW-1:0] opnd;
  logic [1:0][BW-1:0] mag;
  logic [1:0]         sgn;
  logic               zero;
  split_t             nxt;
  split_t             m_q, s_q;
  logic               m_full, s_full;
  logic               acc, fire;
  logic [CNT_W-1:0]   cnt_q;

  assign opnd = {b, a};

  for (genvar i = 0; i < 2; i++) begin : g_abs
    abs_val #(.BW(BW)) u_abs (
      .x    (opnd[i]),
      .sign (sgn[i]),
      .mag  (mag[i])
    );
  end

`ifdef SIGN_MAG_ZERO_SKIP_EN
  assign zero = (a == '0) | (b == '0);
`else
  assign zero = 1'b0;
`endif

  // Assemble the record for an incoming pair.
  always_comb begin
    nxt           = '0;
    nxt.a_sign    = sgn[0];
    nxt.b_sign    = sgn[1];
    nxt.zero_op   = zero;
    nxt.prod_sign = prod_sign_of(sgn[0], sgn[1], zero);
    nxt.a_mag     = MAG_W_MAX'(mag[0]);
    nxt.b_mag     = MAG_W_MAX'(mag[1]);
  end

  // in_ready depends only on the skid flop, so out_ready never reaches it.
  assign in_ready = ~s_full;
  assign acc      = in_valid & ~s_full;
  assign fire     = m_full & out_ready;

  // Main/skid buffer: M drives the outputs, S catches the pair that arrives
  // while M is stalled, and S refills M before any new pair is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q    <= '0;
      s_q    <= '0;
      m_full <= 1'b0;
      s_full <= 1'b0;
    end else if (fire) begin
      if (s_full) begin
        m_q    <= s_q;
        s_full <= 1'b0;
      end else if (acc) begin
        m_q    <= nxt;
      end else begin
        m_full <= 1'b0;
      end
    end else if (acc) begin
      if (!m_full) begin
        m_q    <= nxt;
        m_full <= 1'b1;
      end else begin
        s_q    <= nxt;
        s_full <= 1'b1;
      end
    end
  end

  // Accepted-pair counter, held at all-ones once saturated.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (acc && (cnt_q != '1))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign out_valid = m_full;
  assign a_sign    = m_q.a_sign;
  assign b_sign    = m_q.b_sign;
  assign prod_sign = m_q.prod_sign;
  assign zero_op   = m_q.zero_op;
  assign a_mag     = m_q.a_mag[BW-1:0];
  assign b_mag     = m_q.b_mag[BW-1:0];
  assign op_count  = cnt_q;

  // Record bits above BW are always zero and intentionally left unread.
  if (BW < MAG_W_MAX) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{m_q.a_mag[MAG_W_MAX-1:BW], m_q.b_mag[MAG_W_MAX-1:BW],
                         s_q.a_mag[MAG_W_MAX-1:BW], s_q.b_mag[MAG_W_MAX-1:BW]};
  end

endmodule

// File: tb/tb_sign_mag_split.sv
// Directed and randomized checks for sign_mag_split (BW=8, CNT_W=4).
module tb_sign_mag_split;

  localparam int BW    = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [BW-1:0]    a, b, a_mag, b_mag;
  logic             a_sign, b_sign, prod_sign, zero_op;
  logic [CNT_W-1:0] op_count;

  int n_cmp = 0;
  int n_bad = 0;

  // {out_valid, a_sign, b_sign, prod_sign, zero_op, a_mag, b_mag}
  logic [20:0] obs;
  assign obs = {out_valid, a_sign, b_sign, prod_sign, zero_op, a_mag, b_mag};

  always #5 clk = ~clk;

  sign_mag_split #(.BW(BW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .a_sign(a_sign), .b_sign(b_sign), .a_mag(a_mag), .b_mag(b_mag),
    .prod_sign(prod_sign), .zero_op(zero_op), .op_count(op_count)
  );

  // Reference: expected visible record (with out_valid=1) for operands x, y.
  function automatic logic [20:0] ref_vec(input logic [7:0] x, input logic [7:0] y);
    int xi, yi;
    logic sx, sy, z, ps;
    logic [7:0] mx, my;
    xi = int'($signed(x));
    yi = int'($signed(y));
    sx = (xi < 0);
    sy = (yi < 0);
    mx = 8'((xi < 0) ? -xi : xi);
    my = 8'((yi < 0) ? -yi : yi);
`ifdef SIGN_MAG_ZERO_SKIP_EN
    z  = (xi == 0) || (yi == 0);
`else
    z  = 1'b0;
`endif
    ps = z ? 1'b0 : (sx ^ sy);
    return {1'b1, sx, sy, ps, z, mx, my};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] e;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; a = 8'h81; b = 8'h7F;
    tick();
    n_cmp++;
    if (obs !== 21'd0 || op_count !== 4'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h cnt %0d, want 0 cnt 0", obs, op_count);
    end
    rst = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    // Fill M and S, then reset mid-transfer: contents must vanish.
    tick();
    tick();
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL prefill: in_ready %b out_valid %b, want 0 1", in_ready, out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (obs !== 21'd0 || op_count !== 4'd0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_midflight: got %h cnt %0d rdy %b, want 0 0 1", obs, op_count, in_ready);
    end
    tick();
    e = 21'd0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_no_emit: out_valid %b want %b", out_valid, e[20]);
    end
  endtask

  task automatic test_basic();
    logic [20:0] e;
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; a = 8'hFB; b = 8'h03;
    tick();
    e = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 8'd3};
    n_cmp++;
    if (obs !== e || op_count !== 4'd1) begin
      n_bad++; $display("FAIL basic_neg5_3: got %h cnt %0d, want %h cnt 1", obs, op_count, e);
    end
    a = 8'h80; b = 8'hFF;
    tick();
    e = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 8'h01};
    n_cmp++;
    if (obs !== e || op_count !== 4'd2) begin
      n_bad++; $display("FAIL basic_minneg: got %h cnt %0d, want %h cnt 2", obs, op_count, e);
    end
    a = 8'h7F; b = 8'h81;
    tick();
    e = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h7F, 8'h7F};
    n_cmp++;
    if (obs !== e) begin
      n_bad++; $display("FAIL basic_maxpos: got %h want %h", obs, e);
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || op_count !== 4'd3) begin
      n_bad++; $display("FAIL basic_drain: out_valid %b cnt %0d, want 0 3", out_valid, op_count);
    end
  endtask

  task automatic test_zero();
    logic [20:0] e;
    in_valid = 1'b1; out_ready = 1'b1; a = 8'h00; b = 8'hF9;
    tick();
`ifdef SIGN_MAG_ZERO_SKIP_EN
    e = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd7};
`else
    e = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd7};
`endif
    n_cmp++;
    if (obs !== e) begin
      n_bad++; $display("FAIL zero_operand: got %h want %h", obs, e);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; a = 8'd1; b = 8'd1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || a_mag !== 8'd1) begin
      n_bad++; $display("FAIL bp_first: rdy %b vld %b a_mag %0d, want 1 1 1", in_ready, out_valid, a_mag);
    end
    a = 8'd2; b = 8'd2;
    tick();
    a = 8'd3; b = 8'd3;
    n_cmp++;
    if (in_ready !== 1'b0 || a_mag !== 8'd1 || op_count !== 4'd2) begin
      n_bad++; $display("FAIL bp_full: rdy %b a_mag %0d cnt %0d, want 0 1 2", in_ready, a_mag, op_count);
    end
    tick();
    n_cmp++;
    if (in_ready !== 1'b0 || a_mag !== 8'd1 || b_mag !== 8'd1 || op_count !== 4'd2) begin
      n_bad++; $display("FAIL bp_stall: rdy %b mags %0d/%0d cnt %0d, want 0 1/1 2", in_ready, a_mag, b_mag, op_count);
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || a_mag !== 8'd2 || b_mag !== 8'd2 || in_ready !== 1'b1 || op_count !== 4'd2) begin
      n_bad++; $display("FAIL bp_second: vld %b mags %0d/%0d rdy %b cnt %0d, want 1 2/2 1 2", out_valid, a_mag, b_mag, in_ready, op_count);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || a_mag !== 8'd3 || b_mag !== 8'd3 || op_count !== 4'd3) begin
      n_bad++; $display("FAIL bp_third: vld %b mags %0d/%0d cnt %0d, want 1 3/3 3", out_valid, a_mag, b_mag, op_count);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_empty: vld %b want 0", out_valid);
    end
  endtask

  task automatic test_saturate();
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 8'(i); b = 8'(i + 1);
      tick();
      if (i == 14) begin
        n_cmp++;
        if (op_count !== 4'd15) begin
          n_bad++; $display("FAIL sat_reach: cnt %0d want 15", op_count);
        end
      end
    end
    n_cmp++;
    if (op_count !== 4'd15) begin
      n_bad++; $display("FAIL sat_hold: cnt %0d want 15", op_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (obs !== 21'd0 || op_count !== 4'd0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL sat_reset: got %h cnt %0d rdy %b, want 0 0 1", obs, op_count, in_ready);
    end
  endtask

  task automatic test_random();
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [20:0] held;
    logic        stalled;
    logic        acc, fire;
    int          pushed, popped, cyc;
    rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    stalled = 1'b0; held = '0;
    pushed = 0; popped = 0; cyc = 0;
    while ((pushed < 1000 || popped < pushed) && cyc < 20000) begin
      if (stalled) begin
        n_cmp++;
        if (obs !== held) begin
          n_bad++; $display("FAIL rnd_stable cyc %0d: got %h want %h", cyc, obs, held);
        end
      end
      n_cmp++;
      if (out_valid !== (qa.size() > 0) || in_ready !== (qa.size() < 2)) begin
        n_bad++; $display("FAIL rnd_flags cyc %0d: vld %b rdy %b, occupancy %0d", cyc, out_valid, in_ready, qa.size());
      end
      in_valid  = (pushed < 1000) && ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 7))
        0:       begin a = 8'h00; b = 8'($urandom); end
        1:       begin a = 8'h80; b = 8'($urandom); end
        2:       begin a = 8'($urandom); b = 8'h80; end
        default: begin a = 8'($urandom); b = 8'($urandom); end
      endcase
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        n_cmp++;
        if (qa.size() == 0 || obs !== ref_vec(qa[0], qb[0])) begin
          n_bad++; $display("FAIL rnd_data #%0d: got %h want %h", popped, obs,
                            (qa.size() == 0) ? 21'd0 : ref_vec(qa[0], qb[0]));
        end
        if (qa.size() > 0) begin
          void'(qa.pop_front());
          void'(qb.pop_front());
        end
        popped++;
      end
      if (acc) begin
        qa.push_back(a);
        qb.push_back(b);
        pushed++;
      end
      stalled = out_valid && !out_ready;
      held    = obs;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (cyc >= 20000 || popped != 1000) begin
      n_bad++; $display("FAIL rnd_timeout: popped %0d of 1000 in %0d cycles", popped, cyc);
    end
    n_cmp++;
    if (op_count !== 4'd15) begin
      n_bad++; $display("FAIL rnd_count: cnt %0d want 15", op_count);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
